// File: rtl/ofm_pkg.sv
// Shared types and helpers for the OFM stream writer: FSM encoding,
// stride decode, tag layout and output-dimension arithmetic.
package ofm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ofm_state_t;

  localparam logic [3:0] STRIDE2 = 4'd2;
  localparam int         TAGW    = 3;

  // Number of 3x3 window positions along one dimension for the given stride.
  function automatic logic [15:0] out_dim(input logic [15:0] dim, input logic [3:0] stride);
    logic [15:0] span;
    span = dim - 16'd3;
    return (stride == STRIDE2) ? (span >> 1) + 16'd1 : span + 16'd1;
  endfunction

endpackage

// File: rtl/ofm_tag_fifo.sv
// First-word-fall-through FIFO with register storage; the head entry is
// presented combinationally from the read pointer.
module ofm_tag_fifo #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Push is refused whenever full, even if a pop frees a slot this cycle.
  always_comb begin
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    rdata    = mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/ofm_stream_writer.sv
// Collects conv result pixels into a tagged FIFO and replays them as a
// raster OFM stream with row/frame markers and a ready/valid handshake.
module ofm_stream_writer
  import ofm_pkg::*;
#(
  parameter int DATAW      = 8,
  parameter int OFM_CH     = 8,
  parameter int WIDTH_MAX  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [15:0]                cfg_width,
  input  logic [15:0]                cfg_height,
  input  logic [3:0]                 cfg_stride,
  input  logic                       in_vld,
  input  logic [DATAW*OFM_CH-1:0]    in_data,
  output logic                       in_rdy,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [DATAW*OFM_CH-1:0]    out_data,
  output logic                       out_sol,
  output logic                       out_eol,
  output logic                       out_eof,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       err_cfg,
  output logic                       err_overflow
);

  localparam int          PIXW   = DATAW * OFM_CH;
  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CAP    = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] W_MAX  = 16'(WIDTH_MAX);

  ofm_state_t  state_q, state_d;
  logic [15:0] ow_q, ow_d, oh_q, oh_d;
  logic [15:0] col_q, col_d, row_q, row_d;
  logic        err_overflow_q, err_overflow_d;
  logic        err_cfg_q, err_cfg_d;

  logic                 fifo_full, fifo_empty;
  logic [AW:0]          fifo_count;
  logic [PIXW+TAGW-1:0] fifo_wdata, fifo_rdata;
  logic                 push, cfg_ok;
  logic                 tag_sol, tag_eol, tag_eof;

  ofm_tag_fifo #(
    .WIDTH (PIXW + TAGW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (out_rdy),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    cfg_ok     = (cfg_width >= 16'd3) && (cfg_height >= 16'd3) && (cfg_width <= W_MAX);
    tag_sol    = (col_q == 16'd0);
    tag_eol    = (col_q == ow_q - 16'd1);
    tag_eof    = tag_eol && (row_q == oh_q - 16'd1);
    in_rdy     = (state_q == ST_RUN) && !fifo_full;
    push       = in_vld && in_rdy;
    fifo_wdata = {tag_sol, tag_eol, tag_eof, in_data};

    out_vld                              = !fifo_empty;
    {out_sol, out_eol, out_eof, out_data} = fifo_rdata;
    busy                                 = (state_q != ST_IDLE);
    frame_done                           = (state_q == ST_DONE);
    err_cfg                              = err_cfg_q;
    err_overflow                         = err_overflow_q;
  end

  always_comb begin
    state_d        = state_q;
    ow_d           = ow_q;
    oh_d           = oh_q;
    col_d          = col_q;
    row_d          = row_q;
    err_overflow_d = err_overflow_q;
    err_cfg_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_ok) begin
            ow_d           = out_dim(cfg_width, cfg_stride);
            oh_d           = out_dim(cfg_height, cfg_stride);
            col_d          = 16'd0;
            row_d          = 16'd0;
            err_overflow_d = 1'b0;
            state_d        = ST_RUN;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (push) begin
          if (tag_eol) begin
            col_d = 16'd0;
            row_d = row_q + 16'd1;
          end else begin
            col_d = col_q + 16'd1;
          end
          if (tag_eof) state_d = ST_DRAIN;
        end else if (in_vld && fifo_count == CAP) begin
          // Producer ignores backpressure: the pixel is lost, flag it.
          err_overflow_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_vld && out_rdy && out_eof) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ow_q           <= '0;
      oh_q           <= '0;
      col_q          <= '0;
      row_q          <= '0;
      err_overflow_q <= 1'b0;
      err_cfg_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ow_q           <= ow_d;
      oh_q           <= oh_d;
      col_q          <= col_d;
      row_q          <= row_d;
      err_overflow_q <= err_overflow_d;
      err_cfg_q      <= err_cfg_d;
    end
  end

endmodule

// File: tb/tb_ofm_stream_writer.sv
// Scoreboard bench for ofm_stream_writer: a driver predicts each accepted
// pixel and its raster tags, a monitor checks the output stream in order.
module tb_ofm_stream_writer;

  localparam int PIXW = 64;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_start = 1'b0;
  logic [15:0]     cfg_width = '0;
  logic [15:0]     cfg_height = '0;
  logic [3:0]      cfg_stride = '0;
  logic            in_vld = 1'b0;
  logic [PIXW-1:0] in_data = '0;
  logic            in_rdy;
  logic            out_vld;
  logic            out_rdy = 1'b0;
  logic [PIXW-1:0] out_data;
  logic            out_sol, out_eol, out_eof;
  logic            busy, frame_done, err_cfg, err_overflow;

  ofm_stream_writer dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .cfg_stride   (cfg_stride),
    .in_vld       (in_vld),
    .in_data      (in_data),
    .in_rdy       (in_rdy),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_data     (out_data),
    .out_sol      (out_sol),
    .out_eol      (out_eol),
    .out_eof      (out_eof),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_cfg      (err_cfg),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    bit          sol;
    bit          eol;
    bit          eof;
    int          vis;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_out = 0;

  // Reference model of the frame in progress
  bit frame_active = 1'b0;
  int pushed = 0, total = 0, ow = 0, oh = 0;
  int done_cycle = -1;
  bit err_cfg_exp = 1'b0, ovf_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic zero_checks();
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_err_cfg", 64'(err_cfg), 64'd0);
    chk("rst_err_overflow", 64'(err_overflow), 64'd0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i > 0) zero_checks();
      rst        = 1'b1;
      cfg_start  = 1'($urandom % 2);
      cfg_width  = 16'd8;
      cfg_height = 16'd8;
      cfg_stride = 4'($urandom);
      in_vld     = 1'($urandom % 2);
      in_data    = {$urandom, $urandom};
      out_rdy    = 1'($urandom % 2);
      q.delete();
      frame_active = 1'b0;
      pushed = 0; total = 0;
      done_cycle = -1;
      err_cfg_exp = 1'b0;
      ovf_exp = 1'b0;
    end
    @(posedge clk); #1;
    zero_checks();
    rst = 1'b0; cfg_start = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
  endtask

  // One clock of stimulus; checks the registered outputs against the model
  // for the current cycle, then drives inputs and advances the model.
  task automatic step(input bit st, input int w, input int h, input int s,
                      input bit vld, input logic [63:0] d, input bit rdy);
    bit busy_now, open, full_now;
    int col, row, div;
    exp_t e;
    @(posedge clk); #1;
    busy_now = frame_active || (cyc == done_cycle);
    open     = frame_active && (pushed < total);
    full_now = (q.size() >= DEPTH);
    chk("busy", 64'(busy), 64'(busy_now));
    chk("in_rdy", 64'(in_rdy), 64'(open && !full_now));
    chk("err_cfg", 64'(err_cfg), 64'(err_cfg_exp));
    chk("err_overflow", 64'(err_overflow), 64'(ovf_exp));

    cfg_start = st; cfg_width = 16'(w); cfg_height = 16'(h); cfg_stride = 4'(s);
    in_vld = vld; in_data = d; out_rdy = rdy;
    err_cfg_exp = 1'b0;

    if (vld && open) begin
      if (!full_now) begin
        col   = pushed % ow;
        row   = pushed / ow;
        e.data = d;
        e.sol  = (col == 0);
        e.eol  = (col == ow - 1);
        e.eof  = (col == ow - 1) && (row == oh - 1);
        e.vis  = cyc + 1;
        q.push_back(e);
        pushed++;
      end else begin
        ovf_exp = 1'b1;
      end
    end

    if (st && !busy_now) begin
      if (w >= 3 && h >= 3 && w <= 64) begin
        div = (s == 2) ? 2 : 1;
        ow = (w - 3) / div + 1;
        oh = (h - 3) / div + 1;
        total = ow * oh;
        pushed = 0;
        frame_active = 1'b1;
        ovf_exp = 1'b0;
      end else begin
        err_cfg_exp = 1'b1;
      end
    end
  endtask

  task automatic start(input int w, input int h, input int s);
    step(1'b1, w, h, s, 1'b0, '0, 1'b1);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 0, 0, 0, 1'b0, '0, rdy);
  endtask

  task automatic wait_done(input bit rand_rdy);
    int k = 0;
    while ((frame_active || cyc <= done_cycle) && k < 3000) begin
      idle(rand_rdy ? 1'($urandom % 10 < 7) : 1'b1);
      k++;
    end
    chk("frame_timeout", 64'(frame_active), 64'd0);
  endtask

  // Monitor: compares the head of the stream with the scoreboard every cycle.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("frame_done", 64'(frame_done), 64'(cyc == done_cycle));
      chk("out_vld", 64'(out_vld), 64'(q.size() > 0 && q[0].vis <= cyc));
      if (out_vld && q.size() > 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_sol", 64'(out_sol), 64'(q[0].sol));
        chk("out_eol", 64'(out_eol), 64'(q[0].eol));
        chk("out_eof", 64'(out_eof), 64'(q[0].eof));
        if (out_rdy) begin
          n_out++;
          $display("out #%0d cycle %0d data=%h sol=%0d eol=%0d eof=%0d",
                   n_out, cyc, out_data, out_sol, out_eol, out_eof);
          if (q[0].eof) begin
            frame_active = 1'b0;
            done_cycle = cyc + 1;
          end
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int g;
    do_reset(2);

    // 5x4 stride 1 -> 3x2 output, streaming with no backpressure
    start(5, 4, 1);
    for (int k = 1; k <= 6; k++) step(1'b0, 0, 0, 0, 1'b1, 64'(k), 1'b1);
    wait_done(1'b0);

    // 7x7 stride 2 -> 3x3 output
    start(7, 7, 2);
    for (int k = 1; k <= 9; k++) step(1'b0, 0, 0, 0, 1'b1, {$urandom, $urandom}, 1'b1);
    wait_done(1'b0);

    // Fill the FIFO under a stall, overflow with pixel 17, then drain
    start(64, 64, 1);
    for (int k = 1; k <= 17; k++) step(1'b0, 0, 0, 0, 1'b1, 64'(k), 1'b0);
    for (int k = 0; k < 3; k++) idle(1'b0);
    for (int k = 0; k < 20; k++) idle(1'b1);
    do_reset(1);

    // Rejected configurations: no frame, no output
    start(2, 4, 1);
    for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 0, 1'b1, {$urandom, $urandom}, 1'b1);
    start(65, 4, 1);
    for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 0, 1'b1, {$urandom, $urandom}, 1'b1);
    start(8, 2, 2);
    idle(1'b1);
    idle(1'b1);

    // Reset mid-frame, then a 1x1-output frame
    start(5, 4, 1);
    for (int k = 1; k <= 3; k++) step(1'b0, 0, 0, 0, 1'b1, 64'(k), 1'b1);
    do_reset(1);
    start(3, 3, 1);
    step(1'b0, 0, 0, 0, 1'b1, 64'hA5A5_0000_1234_5678, 1'b1);
    wait_done(1'b0);

    // Random frames with random valid and ready
    for (int f = 0; f < 6; f++) begin
      start(int'($urandom_range(3, 9)), int'($urandom_range(3, 9)), int'($urandom_range(0, 3)));
      g = 0;
      while (frame_active && pushed < total && g < 3000) begin
        step(1'b0, 0, 0, 0, 1'($urandom % 10 < 6), {$urandom, $urandom}, 1'($urandom % 10 < 7));
        g++;
      end
      wait_done(1'b1);
    end

    for (int k = 0; k < 3; k++) idle(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
